// File: rtl/pcalc_pipe_n_if.sv
// pcalc_pipe_n_if
//   Bus bundle for the intersection-point calculator.
//   Request side  : in_valid/in_stall handshake with ray ID, triangle ID,
//                   miss flag, origin {z,y,x}, direction {z,y,x} and hit distance t.
//   Result side   : out_valid/out_stall handshake with ray ID, triangle ID,
//                   miss flag, intersection point {z,y,x} and pass-through direction.
//   occupancy     : credits in use (pipeline + output FIFO).
//   Modports:
//     master - the request source / result sink (ray store + shader side)
//     slave  - the calculator itself
interface pcalc_pipe_n_if #(
   parameter int W          = 32,
   parameter int ID_W       = 16,
   parameter int TRI_W      = 16,
   parameter int FIFO_DEPTH = 8
);
   logic                         in_valid;
   logic                         in_stall;
   logic [ID_W-1:0]              in_ray_id;
   logic [TRI_W-1:0]             in_tri_id;
   logic                         in_miss;
   logic [3*W-1:0]               in_org;
   logic [3*W-1:0]               in_dir;
   logic [W-1:0]                 in_t;

   logic                         out_valid;
   logic                         out_stall;
   logic [ID_W-1:0]              out_ray_id;
   logic [TRI_W-1:0]             out_tri_id;
   logic                         out_miss;
   logic [3*W-1:0]               out_pos;
   logic [3*W-1:0]               out_dir;

   logic [$clog2(FIFO_DEPTH):0]  occupancy;

   modport master (
      output in_valid, in_ray_id, in_tri_id, in_miss, in_org, in_dir, in_t,
      input  in_stall,
      input  out_valid, out_ray_id, out_tri_id, out_miss, out_pos, out_dir,
      output out_stall,
      input  occupancy
   );

   modport slave (
      input  in_valid, in_ray_id, in_tri_id, in_miss, in_org, in_dir, in_t,
      output in_stall,
      output out_valid, out_ray_id, out_tri_id, out_miss, out_pos, out_dir,
      input  out_stall,
      output occupancy
   );
endinterface

// File: rtl/pcalc_pipe_n.sv
// pcalc_pipe_n
//   Intersection-point calculator: pos = org + t*dir per component in signed
//   Q(W-FRAC).FRAC, saturated to W bits. Results pass through LAT always-advancing
//   stages into an output FIFO; ray ID, triangle ID, direction and miss flag ride
//   alongside. A credit counter (pipe + FIFO entries) stalls the request side so
//   every in-flight result is guaranteed a FIFO slot on exit.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - pcalc_pipe_n_if.slave (request side, result side, occupancy)
module pcalc_pipe_n #(
   parameter int W          = 32,
   parameter int FRAC       = 16,
   parameter int ID_W       = 16,
   parameter int TRI_W      = 16,
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   pcalc_pipe_n_if.slave bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   // Clamp a 2W+1 signed sum into W bits: in range iff the bits above the
   // W-bit sign position are all copies of the sign.
   function automatic logic signed [W-1:0] sat_fn(input logic signed [2*W:0] v);
      if (v[2*W:W-1] == {(W+2){v[2*W]}})
         return v[W-1:0];
      else if (v[2*W])
         return {1'b1, {(W-1){1'b0}}};
      else
         return {1'b0, {(W-1){1'b1}}};
   endfunction

   function automatic logic signed [W-1:0] pos_fn(
      input logic signed [W-1:0] org,
      input logic signed [W-1:0] dir,
      input logic signed [W-1:0] t
   );
      logic signed [2*W-1:0] prod;
      logic signed [2*W:0]   sum;
      prod = (2*W)'(t) * (2*W)'(dir);
      sum  = (2*W+1)'(org) + (2*W+1)'(prod >>> FRAC);
      return sat_fn(sum);
   endfunction

   logic                  stall;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      fcnt;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [3*W-1:0]        pos_calc;

   logic                  vld_p    [LAT];
   logic [ID_W-1:0]       ray_id_p [LAT];
   logic [TRI_W-1:0]      tri_id_p [LAT];
   logic                  miss_p   [LAT];
   logic [3*W-1:0]        pos_p    [LAT];
   logic [3*W-1:0]        dir_p    [LAT];

   logic [ID_W-1:0]       mem_ray_id [FIFO_DEPTH];
   logic [TRI_W-1:0]      mem_tri_id [FIFO_DEPTH];
   logic                  mem_miss   [FIFO_DEPTH];
   logic [3*W-1:0]        mem_pos    [FIFO_DEPTH];
   logic [3*W-1:0]        mem_dir    [FIFO_DEPTH];

   // Stall depends on the credit register only; a pop at a full edge frees
   // the credit for the following cycle, never the same one.
   assign stall  = (cnt == CNT_W'(FIFO_DEPTH));
   assign accept = bus.in_valid & ~stall;
   assign push   = vld_p[LAT-1];
   assign empty  = (fcnt == '0);
   assign full   = (fcnt == CNT_W'(FIFO_DEPTH));
   assign pop    = ~empty & ~bus.out_stall;

   // ---- stage p0 input: combinational multiply-add-saturate ----
   always_comb begin
      pos_calc = '0;
      if (!bus.in_miss) begin
         for (int c = 0; c < 3; c++) begin
            pos_calc[c*W +: W] = pos_fn($signed(bus.in_org[c*W +: W]),
                                        $signed(bus.in_dir[c*W +: W]),
                                        $signed(bus.in_t));
         end
      end
   end

   // ---- stages p0..p(LAT-1): valid chain ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) vld_p[i] <= 1'b0;
      end else begin
         vld_p[0] <= accept;
         for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   // ---- stages p0..p(LAT-1): data chain, qualified by vld_p ----
   always_ff @(posedge clk) begin
      ray_id_p[0] <= bus.in_ray_id;
      tri_id_p[0] <= bus.in_tri_id;
      miss_p[0]   <= bus.in_miss;
      pos_p[0]    <= pos_calc;
      dir_p[0]    <= bus.in_dir;
      for (int i = 1; i < LAT; i++) begin
         ray_id_p[i] <= ray_id_p[i-1];
         tri_id_p[i] <= tri_id_p[i-1];
         miss_p[i]   <= miss_p[i-1];
         pos_p[i]    <= pos_p[i-1];
         dir_p[i]    <= dir_p[i-1];
      end
   end

   // ---- output FIFO and credit counter ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcnt   <= '0;
         cnt    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_ray_id[i] <= '0;
            mem_tri_id[i] <= '0;
            mem_miss[i]   <= 1'b0;
            mem_pos[i]    <= '0;
            mem_dir[i]    <= '0;
         end
      end else begin
         if (push) begin
            mem_ray_id[wr_ptr] <= ray_id_p[LAT-1];
            mem_tri_id[wr_ptr] <= tri_id_p[LAT-1];
            mem_miss[wr_ptr]   <= miss_p[LAT-1];
            mem_pos[wr_ptr]    <= pos_p[LAT-1];
            mem_dir[wr_ptr]    <= dir_p[LAT-1];
            wr_ptr             <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

         case ({push, pop})
            2'b10:   fcnt <= fcnt + CNT_W'(1);
            2'b01:   fcnt <= fcnt - CNT_W'(1);
            default: fcnt <= fcnt;
         endcase

         case ({accept, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         assert (!(push && full));
         assert (!(pop && empty));
      end
   end

   assign bus.in_stall   = stall;
   assign bus.occupancy  = cnt;
   assign bus.out_valid  = ~empty;
   assign bus.out_ray_id = mem_ray_id[rd_ptr];
   assign bus.out_tri_id = mem_tri_id[rd_ptr];
   assign bus.out_miss   = mem_miss[rd_ptr];
   assign bus.out_pos    = mem_pos[rd_ptr];
   assign bus.out_dir    = mem_dir[rd_ptr];

endmodule

// File: tb/tb_pcalc_pipe_n.sv
// tb_pcalc_pipe_n
//   Directed bench for pcalc_pipe_n: a scoreboard queue is filled at each
//   accepted request and drained by a negedge monitor at each pop.
module tb_pcalc_pipe_n;
   localparam int W          = 32;
   localparam int FRAC       = 16;
   localparam int ID_W       = 16;
   localparam int TRI_W      = 16;
   localparam int LAT        = 3;
   localparam int FIFO_DEPTH = 8;

   typedef struct packed {
      logic [ID_W-1:0]  ray_id;
      logic [TRI_W-1:0] tri_id;
      logic             miss;
      logic [3*W-1:0]   pos;
      logic [3*W-1:0]   dir;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb[$];
   exp_t mon_e;

   pcalc_pipe_n_if #(.W(W), .ID_W(ID_W), .TRI_W(TRI_W), .FIFO_DEPTH(FIFO_DEPTH)) ifc ();

   pcalc_pipe_n #(.W(W), .FRAC(FRAC), .ID_W(ID_W), .TRI_W(TRI_W), .LAT(LAT),
                  .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return {z, y, x};
   endfunction

   // Reference: exact 64-bit integer arithmetic, then clamp.
   function automatic logic [31:0] mdl(input logic [31:0] o, input logic [31:0] d, input logic [31:0] t);
      longint p;
      longint s;
      p = longint'($signed(t)) * longint'($signed(d));
      s = longint'($signed(o)) + (p >>> FRAC);
      if (s > 64'sd2147483647)  return 32'h7FFFFFFF;
      if (s < -64'sd2147483648) return 32'h80000000;
      return s[31:0];
   endfunction

   function automatic logic [95:0] exp_pos(input logic [95:0] org, input logic [95:0] dir,
                                           input logic [31:0] t, input logic miss);
      logic [95:0] r;
      r = '0;
      if (!miss)
         for (int c = 0; c < 3; c++) r[c*32 +: 32] = mdl(org[c*32 +: 32], dir[c*32 +: 32], t);
      return r;
   endfunction

   // Present a request (caller sits just after a rising edge) and hold it until accepted.
   task automatic send(input logic [15:0] id, input logic [15:0] tid, input logic miss,
                       input logic [95:0] org, input logic [95:0] dir, input logic [31:0] t);
      bit   done;
      exp_t e;
      done          = 1'b0;
      ifc.in_ray_id = id;
      ifc.in_tri_id = tid;
      ifc.in_miss   = miss;
      ifc.in_org    = org;
      ifc.in_dir    = dir;
      ifc.in_t      = t;
      ifc.in_valid  = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (!ifc.in_stall) begin
            @(posedge clk);
            e.ray_id = id;
            e.tri_id = tid;
            e.miss   = miss;
            e.pos    = exp_pos(org, dir, t, miss);
            e.dir    = dir;
            sb.push_back(e);
            done = 1'b1;
         end else begin
            @(posedge clk);
         end
         #1;
      end
      ifc.in_valid = 1'b0;
      if (!done) begin
         n_chk++;
         n_fail++;
         $error("FAIL send_timeout id=%0h observed=stalled expected=accepted", id);
      end
   endtask

   task automatic drain();
      bit done;
      done          = 1'b0;
      ifc.out_stall = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         if (sb.size() == 0 && !ifc.out_valid) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $error("FAIL drain_timeout observed=%0d pending expected=0", sb.size());
      end
   endtask

   // Monitor: a pop happens at the next rising edge whenever out_valid & ~out_stall.
   always @(negedge clk) begin
      if (!rst && ifc.out_valid && !ifc.out_stall) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL unexpected_output observed=id %0h expected=none", ifc.out_ray_id);
         end else begin
            mon_e = sb.pop_front();
            check("out_ray_id", ifc.out_ray_id, mon_e.ray_id);
            check("out_tri_id", ifc.out_tri_id, mon_e.tri_id);
            check("out_miss",   ifc.out_miss,   mon_e.miss);
            check("out_pos",    ifc.out_pos,    mon_e.pos);
            check("out_dir",    ifc.out_dir,    mon_e.dir);
         end
      end
   end

   initial begin
      ifc.in_valid  = 1'b0;
      ifc.in_ray_id = '0;
      ifc.in_tri_id = '0;
      ifc.in_miss   = 1'b0;
      ifc.in_org    = '0;
      ifc.in_dir    = '0;
      ifc.in_t      = '0;
      ifc.out_stall = 1'b0;

      // Reset state
      #3;
      check("rst_out_valid", ifc.out_valid, 1'b0);
      check("rst_in_stall",  ifc.in_stall,  1'b0);
      check("rst_occupancy", ifc.occupancy, 4'd0);
      check("rst_out_pos",   ifc.out_pos,   96'd0);
      check("rst_out_ray_id", ifc.out_ray_id, 16'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1. Basic Q16.16 point and latency
      send(16'h0001, 16'h0101, 1'b0, v3(32'h00010000, 32'h00020000, 32'hFFFD0000),
           v3(32'h00008000, 32'h00000000, 32'h00010000), 32'h00040000);
      for (int i = 0; i <= LAT; i++) begin
         @(negedge clk);
         if (i < LAT) check("lat_out_valid_low", ifc.out_valid, 1'b0);
         else begin
            check("lat_out_valid_high", ifc.out_valid, 1'b1);
            check("t1_pos", ifc.out_pos, v3(32'h00030000, 32'h00020000, 32'h00010000));
         end
      end
      @(posedge clk);
      #1;
      drain();

      // 2. Saturation, both directions
      ifc.out_stall = 1'b1;
      send(16'h0002, 16'h0202, 1'b0, v3(32'h0, 32'h0, 32'h0),
           v3(32'h7FFF0000, 32'h00010000, 32'h0), 32'h7FFF0000);
      send(16'h0003, 16'h0303, 1'b0, v3(32'h0, 32'h0, 32'h0),
           v3(32'h80010000, 32'h00010000, 32'h0), 32'h7FFF0000);
      repeat (LAT + 1) @(posedge clk);
      @(negedge clk);
      check("sat_pos_x_pos", ifc.out_pos[31:0], 32'h7FFFFFFF);
      @(posedge clk);
      #1;
      ifc.out_stall = 1'b0;
      @(posedge clk);
      #1;
      ifc.out_stall = 1'b1;
      @(negedge clk);
      check("sat_pos_x_neg", ifc.out_pos[31:0], 32'h80000000);
      @(posedge clk);
      #1;
      drain();

      // 3. Backpressure: 8 accepted, 9th held
      ifc.out_stall = 1'b1;
      for (int i = 0; i < 8; i++)
         send(16'h0030 + 16'(i), 16'h0A00 + 16'(i), 1'b0, v3(32'(i) << 16, 32'h00010000, 32'h0),
              v3(32'h00010000, 32'hFFFF0000, 32'h00008000), 32'h00020000);
      @(negedge clk);
      check("bp_in_stall",  ifc.in_stall,  1'b1);
      check("bp_occupancy", ifc.occupancy, 4'd8);
      @(posedge clk);
      #1;
      ifc.in_ray_id = 16'h0038;
      ifc.in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_hold_occupancy", ifc.occupancy, 4'd8);
         @(posedge clk);
         #1;
      end
      ifc.out_stall = 1'b0;
      send(16'h0038, 16'h0A08, 1'b0, v3(32'h0, 32'h0, 32'h0), v3(32'h00010000, 32'h0, 32'h0), 32'h00010000);
      send(16'h0039, 16'h0A09, 1'b0, v3(32'h0, 32'h0, 32'h0), v3(32'h00020000, 32'h0, 32'h0), 32'h00010000);
      drain();

      // 4. Full + single pop with a pending request
      ifc.out_stall = 1'b1;
      for (int i = 0; i < 8; i++)
         send(16'h0040 + 16'(i), 16'h0B00, 1'b0, v3(32'h0, 32'h0, 32'h0),
              v3(32'h0, 32'(i) << 16, 32'h0), 32'h00010000);
      repeat (LAT) @(posedge clk);
      #1;
      ifc.in_ray_id = 16'h0048;
      ifc.in_tri_id = 16'h0B08;
      ifc.in_miss   = 1'b0;
      ifc.in_org    = v3(32'h00050000, 32'h0, 32'h0);
      ifc.in_dir    = v3(32'h0, 32'h0, 32'h00010000);
      ifc.in_t      = 32'h00030000;
      ifc.in_valid  = 1'b1;
      ifc.out_stall = 1'b0;
      @(negedge clk);
      check("fp_stall_before_pop", ifc.in_stall, 1'b1);
      @(posedge clk);
      #1;
      ifc.out_stall = 1'b1;
      @(negedge clk);
      check("fp_occupancy_after_pop", ifc.occupancy, 4'd7);
      check("fp_stall_after_pop", ifc.in_stall, 1'b0);
      @(posedge clk);
      sb.push_back('{ray_id: 16'h0048, tri_id: 16'h0B08, miss: 1'b0,
                     pos: exp_pos(v3(32'h00050000, 32'h0, 32'h0), v3(32'h0, 32'h0, 32'h00010000),
                                  32'h00030000, 1'b0),
                     dir: v3(32'h0, 32'h0, 32'h00010000)});
      #1;
      ifc.in_valid = 1'b0;
      @(negedge clk);
      check("fp_occupancy_refull", ifc.occupancy, 4'd8);
      check("fp_stall_refull", ifc.in_stall, 1'b1);
      @(posedge clk);
      #1;
      drain();

      // 5. Miss / hit interleave
      for (int i = 1; i <= 6; i++)
         send(16'(i), 16'h0C00 + 16'(i), (i % 2) == 1, v3(32'h00010000, 32'h00020000, 32'h00030000),
              v3(32'(i) << 16, 32'h00008000, 32'hFFFF0000), 32'h00020000);
      drain();

      // Random hits
      for (int i = 0; i < 16; i++)
         send(16'h0100 + 16'(i), 16'($urandom), 1'($urandom_range(0, 1)),
              {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, $urandom);
      drain();

      // 6. Reset mid-stream: 4 in FIFO, 3 in pipe
      ifc.out_stall = 1'b1;
      for (int i = 0; i < 7; i++)
         send(16'h0060 + 16'(i), 16'h0D00, 1'b0, v3(32'h0, 32'h0, 32'h0),
              v3(32'h00010000, 32'h0, 32'h0), 32'h00010000);
      @(negedge clk);
      check("mr_occupancy_before", ifc.occupancy, 4'd7);
      check("mr_out_valid_before", ifc.out_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("mr_out_valid", ifc.out_valid, 1'b0);
      check("mr_occupancy", ifc.occupancy, 4'd0);
      check("mr_in_stall",  ifc.in_stall,  1'b0);
      check("mr_out_ray_id", ifc.out_ray_id, 16'd0);
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ifc.out_stall = 1'b0;
      for (int i = 0; i < LAT + FIFO_DEPTH + 2; i++) begin
         @(negedge clk);
         check("mr_no_stale", ifc.out_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      send(16'h0070, 16'h0E00, 1'b0, v3(32'h00010000, 32'h0, 32'h0),
           v3(32'h00010000, 32'h00010000, 32'h00010000), 32'h00010000);
      drain();
      check("sb_empty", 128'(sb.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
